// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcode, state and control-field encodings for the multi-cycle MIPS control path
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } ctrlState;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic isSupported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - main control FSM sequencing fetch/decode/execute/memory/write-back
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       iclk,
    input  logic       irst_n,
    input  logic [5:0] iOpcode,
    input  logic       iMemReady,
    output logic       oPCWrite,
    output logic       oPCWriteCond,
    output logic       oIorD,
    output logic       oMemRead,
    output logic       oMemWrite,
    output logic       oMemtoReg,
    output logic       oIRWrite,
    output logic       oALUSrcA,
    output logic       oRegWrite,
    output logic       oRegDst,
    output logic [1:0] oPCSource,
    output logic [1:0] oALUSrcB,
    output logic [1:0] oALUOp,
    output logic       oIllegal
);

    ctrlState state;
    ctrlState nextState;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= S_RESET;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            S_RESET:  nextState = S_FETCH;
            S_FETCH:  if (iMemReady) nextState = S_DECODE;
            S_DECODE: begin
                unique case (iOpcode)
                    OP_RTYPE:      nextState = S_EXEC;
                    OP_LW, OP_SW:  nextState = S_MEMADR;
                    OP_BEQ:        nextState = S_BRANCH;
                    OP_J:          nextState = S_JUMP;
                    OP_ADDI:       nextState = S_ADDIEX;
                    default:       nextState = S_FETCH;
                endcase
            end
            S_MEMADR: nextState = (iOpcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (iMemReady) nextState = S_MEMWB;
            S_MEMWR:  if (iMemReady) nextState = S_FETCH;
            S_EXEC:   nextState = S_RWB;
            S_ADDIEX: nextState = S_ADDIWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: nextState = S_FETCH;
            default:  nextState = S_RESET;
        endcase
    end

    // Moore decode of the state, except the FETCH ready qualifiers and the DECODE illegal flag.
    always_comb begin
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oIorD        = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oMemtoReg    = 1'b0;
        oIRWrite     = 1'b0;
        oALUSrcA     = 1'b0;
        oRegWrite    = 1'b0;
        oRegDst      = 1'b0;
        oPCSource    = PCSRC_ALU;
        oALUSrcB     = SRCB_REGB;
        oALUOp       = ALUOP_ADD;
        oIllegal     = 1'b0;
        unique case (state)
            S_FETCH: begin
                oMemRead = 1'b1;
                oALUSrcB = SRCB_FOUR;
                oIRWrite = iMemReady;
                oPCWrite = iMemReady;
            end
            S_DECODE: begin
                oALUSrcB = SRCB_IMMSH;
                oIllegal = !isSupported(iOpcode);
            end
            S_MEMADR, S_ADDIEX: begin
                oALUSrcA = 1'b1;
                oALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                oMemRead = 1'b1;
                oIorD    = 1'b1;
            end
            S_MEMWB: begin
                oRegWrite = 1'b1;
                oMemtoReg = 1'b1;
            end
            S_MEMWR: begin
                oMemWrite = 1'b1;
                oIorD     = 1'b1;
            end
            S_EXEC: begin
                oALUSrcA = 1'b1;
                oALUOp   = ALUOP_FUNCT;
            end
            S_RWB: begin
                oRegWrite = 1'b1;
                oRegDst   = 1'b1;
            end
            S_BRANCH: begin
                oALUSrcA     = 1'b1;
                oALUOp       = ALUOP_SUB;
                oPCWriteCond = 1'b1;
                oPCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                oPCWrite  = 1'b1;
                oPCSource = PCSRC_JUMP;
            end
            S_ADDIWB: oRegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       irWrite;
        logic       aluSrcA;
        logic       regWrite;
        logic       regDst;
        logic [1:0] pcSource;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       illegal;
    } ctlVec;

    logic       iclk = 1'b0;
    logic       irst_n = 1'b0;
    logic [5:0] iOpcode = 6'd0;
    logic       iMemReady = 1'b0;
    logic       oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg;
    logic       oIRWrite, oALUSrcA, oRegWrite, oRegDst, oIllegal;
    logic [1:0] oPCSource, oALUSrcB, oALUOp;
    ctlVec      obs;

    int total = 0;
    int bad = 0;

    ctlVec      expQ[$];
    logic       rdyQ[$];
    logic [5:0] opQ[$];

    mips_multicycle_ctrl dut (
        .iclk(iclk), .irst_n(irst_n), .iOpcode(iOpcode), .iMemReady(iMemReady),
        .oPCWrite(oPCWrite), .oPCWriteCond(oPCWriteCond), .oIorD(oIorD),
        .oMemRead(oMemRead), .oMemWrite(oMemWrite), .oMemtoReg(oMemtoReg),
        .oIRWrite(oIRWrite), .oALUSrcA(oALUSrcA), .oRegWrite(oRegWrite),
        .oRegDst(oRegDst), .oPCSource(oPCSource), .oALUSrcB(oALUSrcB),
        .oALUOp(oALUOp), .oIllegal(oIllegal)
    );

    always #5 iclk = ~iclk;

    assign obs = {oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg, oIRWrite,
                  oALUSrcA, oRegWrite, oRegDst, oPCSource, oALUSrcB, oALUOp, oIllegal};

    // Control word required in each named step of an instruction, straight from the step table.
    function automatic ctlVec ctl(input string step, input logic rdy, input logic ill);
        ctlVec c = '0;
        case (step)
            "FETCH":  begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
            "DECODE": begin c.aluSrcB = 2'b11; c.illegal = ill; end
            "MEMADR": begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            "MEMRD":  begin c.memRead = 1; c.iorD = 1; end
            "MEMWB":  begin c.regWrite = 1; c.memtoReg = 1; end
            "MEMWR":  begin c.memWrite = 1; c.iorD = 1; end
            "EXEC":   begin c.aluSrcA = 1; c.aluOp = 2'b10; end
            "RWB":    begin c.regWrite = 1; c.regDst = 1; end
            "BRANCH": begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
            "JUMP":   begin c.pcWrite = 1; c.pcSource = 2'b10; end
            "ADDIEX": begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
            "ADDIWB": c.regWrite = 1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic void push(input ctlVec e, input logic rdy, input logic [5:0] op);
        expQ.push_back(e);
        rdyQ.push_back(rdy);
        opQ.push_back(op);
    endfunction

    // One instruction as a list of cycles: fw fetch wait cycles, mw memory wait cycles.
    // Inputs the controller must ignore are driven with random junk.
    function automatic void addInstr(input logic [5:0] op, input int fw, input int mw);
        logic legal;
        legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
                (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
        for (int i = 0; i < fw; i++) push(ctl("FETCH", 0, 0), 1'b0, 6'($urandom));
        push(ctl("FETCH", 1, 0), 1'b1, 6'($urandom));
        push(ctl("DECODE", 0, !legal), 1'($urandom), op);
        case (op)
            6'b000000: begin
                push(ctl("EXEC", 0, 0), 1'($urandom), 6'($urandom));
                push(ctl("RWB", 0, 0), 1'($urandom), 6'($urandom));
            end
            6'b100011, 6'b101011: begin
                push(ctl("MEMADR", 0, 0), 1'($urandom), op);
                for (int i = 0; i < mw; i++)
                    push(ctl(op == 6'b100011 ? "MEMRD" : "MEMWR", 0, 0), 1'b0, 6'($urandom));
                push(ctl(op == 6'b100011 ? "MEMRD" : "MEMWR", 0, 0), 1'b1, 6'($urandom));
                if (op == 6'b100011) push(ctl("MEMWB", 0, 0), 1'($urandom), 6'($urandom));
            end
            6'b000100: push(ctl("BRANCH", 0, 0), 1'($urandom), 6'($urandom));
            6'b000010: push(ctl("JUMP", 0, 0), 1'($urandom), 6'($urandom));
            6'b001000: begin
                push(ctl("ADDIEX", 0, 0), 1'($urandom), 6'($urandom));
                push(ctl("ADDIWB", 0, 0), 1'($urandom), 6'($urandom));
            end
            default: ;
        endcase
    endfunction

    function automatic void clearQ();
        expQ.delete();
        rdyQ.delete();
        opQ.delete();
    endfunction

    // Leaves the DUT in RESET just after a rising edge; the next edge enters FETCH.
    task automatic test_reset();
        irst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iMemReady = 1'($urandom);
            iOpcode = 6'($urandom);
            @(negedge iclk);
            total++;
            if (obs !== ctlVec'(0)) begin
                bad++;
                $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, obs, ctlVec'(0));
            end
            @(posedge iclk);
        end
        #1 irst_n = 1'b1;
        @(negedge iclk);
        total++;
        if (obs !== ctlVec'(0)) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs, ctlVec'(0));
        end
        @(posedge iclk);
        #1;
    endtask

    task automatic test_rtype();
        clearQ();
        addInstr(6'b000000, 0, 0);
        addInstr(6'b001000, 0, 0);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL rtype_addi cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_lw_wait();
        clearQ();
        addInstr(6'b100011, 0, 2);
        addInstr(6'b101011, 1, 1);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL lw_sw_wait cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_branch_jump();
        clearQ();
        addInstr(6'b000100, 0, 0);
        addInstr(6'b000010, 0, 0);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL beq_j cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_fetch_stall();
        clearQ();
        addInstr(6'b000000, 4, 0);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL fetch_stall cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_illegal();
        clearQ();
        addInstr(6'b111111, 0, 0);
        addInstr(6'b000010, 0, 0);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b000000};
        clearQ();
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            addInstr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL random cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    // sw stalled in MEMWR, then reset lands mid-cycle: outputs must clear at once.
    task automatic test_reset_mid_access();
        clearQ();
        addInstr(6'b101011, 0, 5);
        for (int i = 0; i < 4; i++) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            if (i < 3) begin
                @(posedge iclk);
                #1;
            end
        end
        #1 irst_n = 1'b0;
        #1;
        total++;
        if (obs !== ctlVec'(0) || oMemWrite !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs, ctlVec'(0));
        end
        @(posedge iclk);
        test_reset();
        clearQ();
        addInstr(6'b000010, 0, 0);
        foreach (expQ[i]) begin
            iMemReady = rdyQ[i];
            iOpcode = opQ[i];
            @(negedge iclk);
            total++;
            if (obs !== expQ[i]) begin
                bad++;
                $display("FAIL rst_mid_resume cyc%0d got=%h exp=%h", i, obs, expQ[i]);
            end
            @(posedge iclk);
            #1;
        end
    endtask

    initial begin
        @(posedge iclk);
        #1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_fetch_stall();
        test_illegal();
        test_random();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multi-cycle MIPS core: sequences instruction fetch, decode, execute, memory and write-back over several clocks, driving every datapath mux select, write enable and the 2-bit ALUOp consumed by the ALU control unit. It sits between the instruction register (opcode source) and the shared datapath (PC, IR, register file, single memory port, ALU). Memory accesses stall on a ready handshake.

## Interface
Parameters:
- none; opcodes, state codes and ALUOp values come from the shared package.

Ports:
- iclk  in  1  clock; all state changes on the rising edge.
- irst_n  in  1  asynchronous, active-low reset.
- iOpcode  in  6  instr[31:26] from the IR; valid from DECODE onward.
- iMemReady  in  1  memory port completes the current access this cycle.
- oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oMemtoReg, oIRWrite, oALUSrcA, oRegWrite, oRegDst  out  1 each  datapath controls.
- oPCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- oALUSrcB  out  2  00 regB, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- oALUOp  out  2  00 add, 01 sub, 10 use funct.
- oIllegal  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- States: RESET, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDIEX, ADDIWB.
- Outputs are a decode of the state register; every output not listed for a state is 0.
- RESET: all outputs 0 -> FETCH unconditionally.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=iMemReady (only Mealy terms). Stays until iMemReady=1, then -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. By iOpcode: 000000 -> EXEC; 100011/101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; anything else -> FETCH with oIllegal=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMRD (lw) or MEMWR (sw).
- MEMRD: MemRead=1, IorD=1; holds until iMemReady -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1; holds until iMemReady -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB. RWB: RegWrite=1, RegDst=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- oMemRead and oMemWrite are never both 1; MemRead/MemWrite held stable while waiting.

## Timing
- irst_n low: state forced to RESET immediately (asynchronous), all outputs 0 in the same cycle, including mid-access; a pending memory access is abandoned.
- First FETCH one cycle after irst_n deasserts.
- Zero-wait latency (FETCH to next FETCH): beq/j 3, R-type/addi/sw 4, lw 5 cycles; each cycle of iMemReady=0 in FETCH/MEMRD/MEMWR adds one.
- iOpcode sampled only in DECODE and MEMADR; changes elsewhere are ignored.
- iMemReady ignored in all states except FETCH, MEMRD, MEMWR.

## Structure
- Package mips_ctrl_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI), state enum (4-bit), ALUOp, ALUSrcB and PCSource encodings; shared with the ALU control unit.
- Single module; next-state and output decode as two combinational blocks plus one state register. No sub-module.

## Test plan
- Reset: irst_n=0 for 3 cycles -> all outputs 0; release -> RESET then FETCH with oMemRead=1, oALUSrcB=01.
- R-type, iMemReady=1: opcode 000000 -> states FETCH,DECODE,EXEC,RWB; EXEC oALUOp=10; RWB oRegWrite=1, oRegDst=1; back to FETCH after 4 cycles.
- lw with 2 wait cycles in MEMRD: opcode 100011 -> MEMRD held 3 cycles with oIorD=1, then MEMWB oMemtoReg=1; total 7 cycles.
- beq and j: 000100 -> BRANCH oPCWriteCond=1, oALUOp=01, oPCSource=01; 000010 -> JUMP oPCWrite=1, oPCSource=10; each 3 cycles.
- Fetch stall: iMemReady=0 for 4 cycles in FETCH -> oIRWrite=oPCWrite=0 throughout, 1 only on ready cycle.
- Illegal opcode 111111 -> oIllegal=1 for exactly one cycle in DECODE, next state FETCH; reset asserted during MEMWR -> outputs 0 that cycle, oMemWrite drops immediately.
